// File: rtl/dyser_cfg_loader.sv
// dyser_cfg_loader
//   Configuration sequencer for the DySER fabric. It holds NUM_SLOTS complete
//   configuration images in local registers. On a request it waits for the
//   fabric to drain and then streams the selected image into the fabric, one
//   word per cycle. When the requested image is already resident, the reload
//   is skipped.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   wr_en/wr_slot/      write one word into the image store
//   wr_addr/wr_data
//   wr_err              one-cycle pulse when a write is rejected
//   cfg_req/cfg_slot    load request and slot, sampled only while idle
//   fabric_idle         fabric has no in-flight data
//   cfg_busy            loader active; the core must keep send/recv quiet
//   cfg_done            one-cycle pulse when the requested image is resident
//   config_bits/        word stream to the fabric
//   config_en
//   loaded_valid/       resident image descriptor
//   loaded_slot
module dyser_cfg_loader #(
  parameter int CFG_WIDTH = 21,
  parameter int CFG_WORDS = 17,
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CFG_WIDTH-1:0] wr_data,
  output logic                 wr_err,
  input  logic                 cfg_req,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic                 fabric_idle,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic [CFG_WIDTH-1:0] config_bits,
  output logic                 config_en,
  output logic                 loaded_valid,
  output logic [SLOT_W-1:0]    loaded_slot
);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] WORDS_C = (ADDR_W+1)'(CFG_WORDS);
  localparam logic [SLOT_W:0] SLOTS_C = (SLOT_W+1)'(NUM_SLOTS);

  state_t                 state;
  state_t                 state_nxt;
  logic [SLOT_W-1:0]      act_slot;
  // One bit wider than a word address so it can count past the last word.
  logic [ADDR_W:0]        idx;
  logic [CFG_WIDTH-1:0]   store [NUM_SLOTS][CFG_WORDS];

  logic wr_ok;
  logic wr_accept;
  logic wr_reject;
  logic wr_hits_loaded;
  logic req_hit;
  logic last_issued;
  logic issue;

  // The active slot is locked against writes from the request edge until the
  // loader returns to IDLE, so the streamed image is always self-consistent.
  assign wr_ok = ({1'b0, wr_addr} < WORDS_C) &&
                 ({1'b0, wr_slot} < SLOTS_C) &&
                 !((state != IDLE) && (wr_slot == act_slot));
  assign wr_accept      = wr_en && wr_ok;
  assign wr_reject      = wr_en && !wr_ok;
  assign wr_hits_loaded = wr_accept && loaded_valid && (wr_slot == loaded_slot);

  // A same-cycle write to the resident slot wins over the request, so it is a miss.
  assign req_hit     = loaded_valid && (cfg_slot == loaded_slot) && !wr_hits_loaded;
  assign last_issued = (idx == WORDS_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (cfg_req) state_nxt = req_hit ? DONE : DRAIN;
      DRAIN: begin
        // Word 0 is registered on the same edge that enters LOAD.
        if (fabric_idle) begin
          state_nxt = LOAD;
          issue     = 1'b1;
        end
      end
      LOAD: begin
        if (last_issued) state_nxt = DONE;
        else             issue     = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Image store: data only, deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (wr_accept) store[wr_slot][wr_addr] <= wr_data;
  end

  // Registered outputs and sequencing control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err       <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      config_en    <= 1'b0;
      config_bits  <= '0;
      loaded_valid <= 1'b0;
      loaded_slot  <= '0;
      act_slot     <= '0;
      idx          <= '0;
    end else begin
      wr_err    <= wr_reject;
      config_en <= issue;
      cfg_busy  <= (state_nxt != IDLE);
      cfg_done  <= (state_nxt == DONE);

      if (issue) begin
        config_bits <= store[act_slot][idx[ADDR_W-1:0]];
        idx         <= idx + (ADDR_W+1)'(1);
      end

      if (wr_hits_loaded) loaded_valid <= 1'b0;

      if (state == IDLE && cfg_req) begin
        act_slot <= cfg_slot;
        if (!req_hit) begin
          loaded_valid <= 1'b0;
          idx          <= '0;
        end
      end

      if (state == LOAD && last_issued) begin
        loaded_valid <= 1'b1;
        loaded_slot  <= act_slot;
      end
    end
  end

endmodule

// File: tb/tb_dyser_cfg_loader.sv
module tb_dyser_cfg_loader;

  localparam int W  = 21;
  localparam int N  = 17;
  localparam int S  = 2;
  localparam int SW = 1;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_slot = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_err;
  logic          cfg_req = 1'b0;
  logic [SW-1:0] cfg_slot = '0;
  logic          fabric_idle = 1'b1;
  logic          cfg_busy;
  logic          cfg_done;
  logic [W-1:0]  config_bits;
  logic          config_en;
  logic          loaded_valid;
  logic [SW-1:0] loaded_slot;

  dyser_cfg_loader #(
    .CFG_WIDTH(W), .CFG_WORDS(N), .NUM_SLOTS(S), .SLOT_W(SW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err),
    .cfg_req(cfg_req), .cfg_slot(cfg_slot), .fabric_idle(fabric_idle),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .config_bits(config_bits), .config_en(config_en),
    .loaded_valid(loaded_valid), .loaded_slot(loaded_slot)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: image contents plus the resident-image descriptor.
  logic [W-1:0] mdl [S][N];
  bit           res_valid = 1'b0;
  int           res_slot  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int slot, input int addr, input logic [W-1:0] data);
    bit rej;
    rej     = (addr >= N);
    wr_en   = 1'b1;
    wr_slot = slot[SW-1:0];
    wr_addr = addr[AW-1:0];
    wr_data = data;
    tick();
    wr_en = 1'b0;
    check("wr_err", wr_err, rej);
    if (!rej) begin
      mdl[slot][addr] = data;
      if (res_valid && res_slot == slot) res_valid = 1'b0;
    end
    check("loaded_valid_after_wr", loaded_valid, res_valid);
  endtask

  // One load request. inj_cycle < 0: no extra write; 0: write in the request
  // cycle; >0: write driven during that cycle of the transaction.
  task automatic request(input int slot, input int stall, input int inj_cycle,
                         input int inj_slot, input int inj_addr, input logic [W-1:0] inj_data);
    bit           hit;
    bit           exp_err = 1'b0;
    bit           busy_bad = 1'b0;
    bit           drain_bad = 1'b0;
    int           cyc = 0;
    int           done_cyc = -1;
    int           first_en = -1;
    int           last_en = -1;
    logic [W-1:0] got[$];
    logic [W-1:0] exp_words [N];

    if (inj_cycle == 0) begin
      exp_err = (inj_addr >= N);
      wr_en   = 1'b1;
      wr_slot = inj_slot[SW-1:0];
      wr_addr = inj_addr[AW-1:0];
      wr_data = inj_data;
      if (!exp_err) begin
        mdl[inj_slot][inj_addr] = inj_data;
        if (res_valid && res_slot == inj_slot) res_valid = 1'b0;
      end
    end

    hit = res_valid && (res_slot == slot);
    for (int i = 0; i < N; i++) exp_words[i] = mdl[slot][i];
    if (!hit) res_valid = 1'b0;

    cfg_slot    = slot[SW-1:0];
    cfg_req     = 1'b1;
    fabric_idle = (stall == 0);

    while (cyc < 80) begin
      tick();
      cyc++;
      cfg_req = 1'b0;
      wr_en   = 1'b0;
      if (inj_cycle >= 0 && cyc == inj_cycle + 1) check("wr_err_pulse", wr_err, exp_err);
      if (config_en) begin
        got.push_back(config_bits);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (!cfg_busy) busy_bad = 1'b1;
      if (!hit && cyc <= stall && (config_en || loaded_valid)) drain_bad = 1'b1;
      if (cfg_done) begin
        done_cyc = cyc;
        break;
      end
      fabric_idle = (cyc > stall);
      if (cyc == inj_cycle) begin
        exp_err = (inj_addr >= N) || (inj_slot == slot);
        wr_en   = 1'b1;
        wr_slot = inj_slot[SW-1:0];
        wr_addr = inj_addr[AW-1:0];
        wr_data = inj_data;
        if (!exp_err) begin
          mdl[inj_slot][inj_addr] = inj_data;
          if (res_valid && res_slot == inj_slot) res_valid = 1'b0;
        end
      end
    end
    wr_en = 1'b0;

    check("done_cycle", done_cyc, hit ? 1 : N + 2 + stall);
    check("busy_during_txn", busy_bad, 0);
    check("drain_quiet", drain_bad, 0);
    check("word_count", got.size(), hit ? 0 : N);
    if (!hit) begin
      check("first_word_cycle", first_en, stall + 2);
      check("contiguous_en", last_en - first_en + 1, N);
      for (int i = 0; i < N && i < got.size(); i++) check($sformatf("word%0d", i), got[i], exp_words[i]);
      res_valid = 1'b1;
      res_slot  = slot;
    end

    tick();
    check("busy_after_done", cfg_busy, 0);
    check("done_pulse_one_cycle", cfg_done, 0);
    check("loaded_valid", loaded_valid, res_valid);
    check("loaded_slot", loaded_slot, res_slot);
  endtask

  initial begin
    logic [W-1:0] d;

    // Reset state
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_config_bits", config_bits, 0);
    check("rst_config_en", config_en, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_loaded_valid", loaded_valid, 0);
    check("rst_loaded_slot", loaded_slot, 0);
    rst = 1'b0;
    tick();

    // Fill images: slot 0 with a directed pattern, slot 1 random
    for (int i = 0; i < N; i++) begin
      d = (i == N - 1) ? W'(2) : W'(i * 8);
      write_word(0, i, d);
    end
    for (int i = 0; i < N; i++) begin
      d = W'($urandom());
      write_word(1, i, d);
    end

    // Miss load, then hit on the same slot
    request(0, 0, -1, 0, 0, '0);
    request(0, 0, -1, 0, 0, '0);

    // Drain stall on slot 1
    request(1, 5, -1, 0, 0, '0);

    // Write invalidation of the resident image
    request(0, 0, -1, 0, 0, '0);
    write_word(0, 3, 21'h1FFFFF);
    request(0, 0, -1, 0, 0, '0);

    // Rejected writes: active slot during LOAD, and out-of-range address
    d = W'($urandom());
    request(1, 0, 6, 1, 4, d);
    write_word(0, 17, W'($urandom()));

    // Accepted write to the other slot mid-load
    d = W'($urandom());
    request(0, 2, 5, 1, 9, d);

    // Write and request to the resident slot in the same cycle: miss
    d = W'($urandom());
    request(0, 0, 0, 0, 2, d);

    // Reset mid-LOAD at word 8
    cfg_slot    = 1'b1;
    cfg_req     = 1'b1;
    fabric_idle = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      cfg_req = 1'b0;
    end
    check("midload_en", config_en, 1);
    check("midload_word8", config_bits, mdl[1][8]);
    #2 rst = 1'b1;
    #1;
    check("rst_async_en", config_en, 0);
    check("rst_async_valid", loaded_valid, 0);
    check("rst_async_busy", cfg_busy, 0);
    #2 rst = 1'b0;
    res_valid = 1'b0;
    tick();
    request(1, 0, -1, 0, 0, '0);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      int sl;
      int st;
      int inj;
      if ($urandom_range(1, 0) == 1) write_word($urandom_range(S - 1, 0), $urandom_range(N + 1, 0), W'($urandom()));
      sl  = $urandom_range(S - 1, 0);
      st  = $urandom_range(3, 0);
      inj = ($urandom_range(2, 0) == 0) ? $urandom_range(N, 0) : -1;
      request(sl, st, inj, $urandom_range(S - 1, 0), $urandom_range(N + 1, 0), W'($urandom()));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/dyser_cfg_loader.md
# dyser_cfg_loader

Configuration sequencer for the DySER fabric. Holds up to NUM_SLOTS complete configuration images in local registers. On request it drains the fabric, then streams the selected image into the fabric's `config_bits`/`config_en` port, one word per cycle. It skips the reload when the requested image is already resident, and sits between the core's dyser_init path and the fabric.

## Interface
Parameters:
- CFG_WIDTH, 21, width of one configuration word
- CFG_WORDS, 17, words per image (≥2)
- NUM_SLOTS, 2, stored images (≥1)
- SLOT_W, 1, slot index width, equal to clog2(NUM_SLOTS) and at least 1
- ADDR_W, 5, word index width, equal to clog2(CFG_WORDS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one word into image store
- wr_slot  in  SLOT_W  slot to write
- wr_addr  in  ADDR_W  word index; values ≥ CFG_WORDS are ignored
- wr_data  in  CFG_WIDTH  word value
- wr_err  out  1  one-cycle pulse when a write is rejected
- cfg_req  in  1  request to load a slot; sampled only in IDLE
- cfg_slot  in  SLOT_W  slot requested
- fabric_idle  in  1  fabric has no in-flight send/recv data
- cfg_busy  out  1  loader active; core must hold send_en/recv_en low
- cfg_done  out  1  one-cycle pulse when the requested image is resident
- config_bits  out  CFG_WIDTH  to fabric
- config_en  out  1  to fabric
- loaded_valid  out  1  a complete image is resident
- loaded_slot  out  SLOT_W  slot of the resident image

## Operation
- Image store: NUM_SLOTS×CFG_WORDS registers, written on wr_en. Not reset; contents persist across rst.
- FSM states: IDLE, DRAIN, LOAD, DONE. Reset enters IDLE.
- IDLE → DONE, when cfg_req=1 and the request hits (loaded_valid=1 and cfg_slot==loaded_slot). The request slot is latched and no config_en is issued.
- IDLE → DRAIN, when cfg_req=1 and the request misses. The slot is latched, loaded_valid is cleared and the word index is set to 0.
- DRAIN → LOAD, when fabric_idle=1. Otherwise the FSM stays in DRAIN indefinitely.
- LOAD: each cycle registers config_en=1 and config_bits=store[latched slot][index], then increments the index. fabric_idle is ignored in LOAD. After index CFG_WORDS-1 is issued, LOAD → DONE.
- DONE: cfg_done=1 for one cycle. On a miss path, loaded_valid←1 and loaded_slot←latched slot. DONE → IDLE.
- cfg_busy=1 in DRAIN, LOAD and DONE. cfg_req outside IDLE is ignored; there is no queueing.
- Write to the latched slot while in DRAIN, LOAD or DONE:
  - the write is rejected and the store is unchanged;
  - wr_err pulses the next cycle.
- Write with wr_addr ≥ CFG_WORDS: rejected, wr_err pulses.
- Accepted write to loaded_slot while loaded_valid=1: loaded_valid←0, so the next request for that slot reloads.
- Write and cfg_req in the same IDLE cycle: the write takes effect first. If it targets loaded_slot, the request is a miss.

## Timing
- All outputs are registered.
- Reset values:
  - config_bits=0, config_en=0
  - cfg_busy=0, cfg_done=0, wr_err=0
  - loaded_valid=0, loaded_slot=0
- Asserting rst mid-load aborts immediately. config_en drops asynchronously and the image is not marked resident.
- Miss latency, with the request sampled on edge 0 and fabric_idle=1:
  - DRAIN occupies cycle 1.
  - Words 0..CFG_WORDS-1 drive config_en in cycles 2..CFG_WORDS+1; for the defaults, cycles 2–18.
  - cfg_done appears in cycle CFG_WORDS+2 (19).
  - Each cycle fabric_idle is low in DRAIN adds one cycle.
- Hit latency: cfg_done in cycle 1. cfg_busy is high for that cycle only, and config_en stays 0.
- config_en is contiguous: exactly CFG_WORDS consecutive cycles per load, with no gaps.
- cfg_busy rises in cycle 1 and falls in the cycle after cfg_done.

## Test plan
- **Reset, then miss load.** Reset; write slot 0 with words 0x000000, 0x000008, …, 0x000002 (17 words); cfg_req slot 0 with fabric_idle=1. Required: config_en high in cycles 2–18 with exact words in order; cfg_done in cycle 19; loaded_valid=1, loaded_slot=0.
- **Hit.** Immediately repeat cfg_req slot 0. Required: cfg_done in cycle 1, no config_en pulse.
- **Drain stall.** cfg_req slot 1 with fabric_idle=0 for 5 cycles. Required: cfg_busy=1 and config_en=0 throughout; first word issues 1 cycle after fabric_idle rises; loaded_valid=0 until done.
- **Write invalidation.** With slot 0 resident, write slot 0 addr 3 = 0x1FFFFF. Required: loaded_valid→0; the next slot 0 request reloads and word 3 = 0x1FFFFF.
- **Rejected writes.**
  - Write to the active slot during LOAD: wr_err pulse, streamed words unchanged.
  - Write with addr 17: wr_err pulse.
- **Reset mid-LOAD.** Assert rst at word 8. Required: config_en=0 immediately; loaded_valid=0; the following request performs a full 17-word load.
